// File: rtl/zx48_pkg.sv
// Shared ZX Spectrum 48K constants: tape pulse lengths (in 3.5 MHz T-state ticks),
// pilot pulse counts, pause length and the tape player state enumeration.
package zx48_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PILOT,
        SYNC1,
        SYNC2,
        DATA,
        PAUSE
    } tapState_t;

    localparam int PULSE_W   = 11;
    localparam int PILOT_LEN = 2168;
    localparam int SYNC1_LEN = 667;
    localparam int SYNC2_LEN = 735;
    localparam int BIT0_LEN  = 855;
    localparam int BIT1_LEN  = 1710;

    localparam int PILOT_W      = 13;
    localparam int PILOT_HEADER = 8063;
    localparam int PILOT_DATA   = 3223;

    localparam int PAUSE_W   = 22;
    localparam int PAUSE_LEN = 3500000;

endpackage

// File: rtl/tap_pulse.sv
// Loadable down-counter advanced on ce && play; done flags a gated tick while the
// count is zero, i.e. the last tick of the current interval.
module tap_pulse #(
    parameter int W = 11
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ce,
    input  logic         play,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] countReg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= value;
        end else if (ce && play && (countReg != '0)) begin
            countReg <= countReg - W'(1);
        end
    end

    assign done = ce && play && (countReg == '0);

endmodule

// File: rtl/tap_player.sv
// Streams TAP block bytes as ZX Spectrum ear pulses (pilot, sync, MSB-first data).
// Define TAP_PLAYER_PAUSE_EN to hold a 1 s silent gap after each block.
module tap_player
    import zx48_pkg::*;
#(
    parameter int PILOT_TICKS        = PILOT_LEN,
    parameter int SYNC1_TICKS        = SYNC1_LEN,
    parameter int SYNC2_TICKS        = SYNC2_LEN,
    parameter int BIT0_TICKS         = BIT0_LEN,
    parameter int BIT1_TICKS         = BIT1_LEN,
    parameter int PILOT_HDR_PULSES   = PILOT_HEADER,
    parameter int PILOT_DATA_PULSES  = PILOT_DATA
`ifdef TAP_PLAYER_PAUSE_EN
    ,
    parameter int PAUSE_TICKS        = PAUSE_LEN
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       play,
    input  logic [7:0] sData,
    input  logic       sValid,
    input  logic       sLast,
    output logic       sReady,
    output logic       ear,
    output logic       busy
);

    tapState_t            stateReg, stateNext;
    logic                 earReg, earNext;
    logic [7:0]           shiftReg, shiftNext;
    logic                 lastReg, lastNext;
    logic [2:0]           bitReg, bitNext;
    logic                 halfReg, halfNext;
    logic                 needByteReg, needByteNext;
    logic [PILOT_W-1:0]   pilotReg, pilotNext;
    logic                 accept;
    logic                 pulseLoad;
    logic [PULSE_W-1:0]   pulseValue;
    logic                 pulseDone;
`ifdef TAP_PLAYER_PAUSE_EN
    logic                 pauseLoad;
    logic                 pauseDone;
`endif

    function automatic logic [PULSE_W-1:0] bitLen(input logic one);
        return one ? PULSE_W'(BIT1_TICKS - 1) : PULSE_W'(BIT0_TICKS - 1);
    endfunction

    tap_pulse #(.W(PULSE_W)) pulseCounter (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .play  (play),
        .load  (pulseLoad),
        .value (pulseValue),
        .done  (pulseDone)
    );

`ifdef TAP_PLAYER_PAUSE_EN
    tap_pulse #(.W(PAUSE_W)) pauseCounter (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .play  (play),
        .load  (pauseLoad),
        .value (PAUSE_W'(PAUSE_TICKS - 1)),
        .done  (pauseDone)
    );
`endif

    always_comb begin
        stateNext    = stateReg;
        earNext      = earReg;
        shiftNext    = shiftReg;
        lastNext     = lastReg;
        bitNext      = bitReg;
        halfNext     = halfReg;
        needByteNext = needByteReg;
        pilotNext    = pilotReg;
        accept       = 1'b0;
        pulseLoad    = 1'b0;
        pulseValue   = '0;
`ifdef TAP_PLAYER_PAUSE_EN
        pauseLoad    = 1'b0;
`endif
        case (stateReg)
            IDLE: begin
                if (play && sValid) begin
                    accept     = 1'b1;
                    earNext    = ~earReg;
                    pulseLoad  = 1'b1;
                    pulseValue = PULSE_W'(PILOT_TICKS - 1);
                    pilotNext  = sData[7] ? PILOT_W'(PILOT_DATA_PULSES - 1)
                                          : PILOT_W'(PILOT_HDR_PULSES - 1);
                    stateNext  = PILOT;
                end
            end
            PILOT: begin
                if (pulseDone) begin
                    earNext   = ~earReg;
                    pulseLoad = 1'b1;
                    if (pilotReg == '0) begin
                        pulseValue = PULSE_W'(SYNC1_TICKS - 1);
                        stateNext  = SYNC1;
                    end else begin
                        pulseValue = PULSE_W'(PILOT_TICKS - 1);
                        pilotNext  = pilotReg - PILOT_W'(1);
                    end
                end
            end
            SYNC1: begin
                if (pulseDone) begin
                    earNext    = ~earReg;
                    pulseLoad  = 1'b1;
                    pulseValue = PULSE_W'(SYNC2_TICKS - 1);
                    stateNext  = SYNC2;
                end
            end
            SYNC2: begin
                if (pulseDone) begin
                    earNext    = ~earReg;
                    pulseLoad  = 1'b1;
                    pulseValue = bitLen(shiftReg[7]);
                    bitNext    = '0;
                    halfNext   = 1'b0;
                    stateNext  = DATA;
                end
            end
            DATA: begin
                // During an underrun the pulse counter sits at zero; only the handshake matters.
                if (needByteReg) begin
                    if (play && sValid) begin
                        accept = 1'b1;
                    end
                end else if (pulseDone) begin
                    if (!halfReg) begin
                        halfNext   = 1'b1;
                        earNext    = ~earReg;
                        pulseLoad  = 1'b1;
                        pulseValue = bitLen(shiftReg[7]);
                    end else if (bitReg != 3'd7) begin
                        bitNext    = bitReg + 3'd1;
                        shiftNext  = {shiftReg[6:0], 1'b0};
                        halfNext   = 1'b0;
                        earNext    = ~earReg;
                        pulseLoad  = 1'b1;
                        pulseValue = bitLen(shiftReg[6]);
                    end else if (lastReg) begin
                        earNext   = 1'b0;
                        stateNext = PAUSE;
`ifdef TAP_PLAYER_PAUSE_EN
                        pauseLoad = 1'b1;
`endif
                    end else if (sValid) begin
                        accept = 1'b1;
                    end else begin
                        needByteNext = 1'b1;
                    end
                end
            end
            PAUSE: begin
`ifdef TAP_PLAYER_PAUSE_EN
                if (pauseDone) begin
                    stateNext = IDLE;
                end
`else
                if (play) begin
                    stateNext = IDLE;
                end
`endif
            end
            default: stateNext = IDLE;
        endcase

        // A byte fetched mid-block starts its first bit pulse in the same cycle.
        if (accept && (stateReg == DATA)) begin
            earNext      = ~earReg;
            pulseLoad    = 1'b1;
            pulseValue   = bitLen(sData[7]);
            bitNext      = '0;
            halfNext     = 1'b0;
            needByteNext = 1'b0;
        end
        if (accept) begin
            shiftNext = sData;
            lastNext  = sLast;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg    <= IDLE;
            earReg      <= 1'b0;
            shiftReg    <= '0;
            lastReg     <= 1'b0;
            bitReg      <= '0;
            halfReg     <= 1'b0;
            needByteReg <= 1'b0;
            pilotReg    <= '0;
        end else begin
            stateReg    <= stateNext;
            earReg      <= earNext;
            shiftReg    <= shiftNext;
            lastReg     <= lastNext;
            bitReg      <= bitNext;
            halfReg     <= halfNext;
            needByteReg <= needByteNext;
            pilotReg    <= pilotNext;
        end
    end

    assign sReady = accept && reset;
    assign ear    = earReg;
    assign busy   = (stateReg != IDLE);

endmodule

// File: tb/tb_tap_player.sv
// Bench for tap_player: randomised ce/data, pulse widths compared with a block-level model.
// The DUT is built with shortened timing constants so that whole blocks fit a short run.
module tb_tap_player;

    localparam int T_PILOT   = 20;
    localparam int T_SYNC1   = 7;
    localparam int T_SYNC2   = 9;
    localparam int T_BIT0    = 11;
    localparam int T_BIT1    = 22;
    localparam int N_HDR     = 13;
    localparam int N_DATA    = 5;
    localparam int GAP_TICKS = 5000;
`ifdef TAP_PLAYER_PAUSE_EN
    localparam int T_PAUSE   = 300;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       ce;
    logic       play;
    logic [7:0] sData;
    logic       sValid;
    logic       sLast;
    logic       sReady;
    logic       ear;
    logic       busy;

    tap_player #(
        .PILOT_TICKS       (T_PILOT),
        .SYNC1_TICKS       (T_SYNC1),
        .SYNC2_TICKS       (T_SYNC2),
        .BIT0_TICKS        (T_BIT0),
        .BIT1_TICKS        (T_BIT1),
        .PILOT_HDR_PULSES  (N_HDR),
        .PILOT_DATA_PULSES (N_DATA)
`ifdef TAP_PLAYER_PAUSE_EN
        ,
        .PAUSE_TICKS       (T_PAUSE)
`endif
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .play   (play),
        .sData  (sData),
        .sValid (sValid),
        .sLast  (sLast),
        .sReady (sReady),
        .ear    (ear),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] feedQ[$];
    bit         lastQ[$];
    logic [7:0] blk[$];
    int         expQ[$];
    int         intervals[$];
    int         edges = 0;
    int         tickAcc = 0;
    int         gapLeft = 0;
    int         gapAfter = -1;
    int         popCount = 0;
    int         gapEdges = 0;
    int         readyViol = 0;
    bit         hsPending = 1'b0;
    bit         lastTickW = 1'b0;
    bit         lastCe = 1'b0;
    logic       earPrev = 1'b0;

    // Input driver: random ce, byte stream from feedQ with an optional gap after a given pop.
    initial begin
        ce = 1'b0; sValid = 1'b0; sData = 8'h00; sLast = 1'b0;
        forever begin
            @(negedge clock);
            if (hsPending) begin
                if (feedQ.size() > 0) begin
                    void'(feedQ.pop_front());
                    void'(lastQ.pop_front());
                end
                popCount++;
                hsPending = 1'b0;
                if (popCount == gapAfter) gapLeft = GAP_TICKS;
            end else if (gapLeft > 0 && lastTickW) begin
                gapLeft--;
            end
            ce     = ($urandom_range(0, 3) != 0);
            sValid = (feedQ.size() > 0) && (gapLeft == 0);
            sData  = sValid ? feedQ[0] : 8'($urandom);
            sLast  = sValid ? lastQ[0] : 1'($urandom);
        end
    end

    // Monitor: ticks between ear edges, handshakes, handshake-rule violations.
    always begin
        @(posedge clock);
        lastTickW = ce && play;
        lastCe    = ce;
        if (sValid && sReady) hsPending = 1'b1;
        if (sReady && !sValid) readyViol++;
        #1;
        tickAcc += int'(lastTickW);
        if (ear !== earPrev) begin
            edges++;
            intervals.push_back(tickAcc);
            tickAcc = 0;
            earPrev = ear;
            if (gapLeft > 0 && gapLeft < GAP_TICKS - 1000) gapEdges++;
        end
    end

    // Reference: the ordered list of pulse widths a block should produce.
    function automatic void buildExpected();
        int nPilot;
        expQ.delete();
        nPilot = blk[0][7] ? N_DATA : N_HDR;
        repeat (nPilot) expQ.push_back(T_PILOT);
        expQ.push_back(T_SYNC1);
        expQ.push_back(T_SYNC2);
        foreach (blk[i]) begin
            for (int b = 7; b >= 0; b--) begin
                repeat (2) expQ.push_back(blk[i][b] ? T_BIT1 : T_BIT0);
            end
        end
    endfunction

    task automatic runBlock(input string name, input int gapAt, input bit freeze);
        int nP, pil, e0, skip, cyc, cnt, changes;
        bit froze;
        logic earHold;
        buildExpected();
        nP  = expQ.size();
        pil = blk[0][7] ? N_DATA : N_HDR;
        @(negedge clock); #1;
        intervals.delete();
        e0 = edges; gapEdges = 0; popCount = 0; gapAfter = gapAt;
        foreach (blk[i]) begin
            feedQ.push_back(blk[i]);
            lastQ.push_back(i == blk.size() - 1);
        end
        skip  = (gapAt > 0) ? (pil + 2 + 16 * gapAt - 1) : -1;
        cyc   = 0;
        froze = 1'b0;
        while ((edges - e0 < nP + 1) && cyc < 30000) begin
            @(negedge clock);
            cyc++;
            if (freeze && !froze && (edges - e0 == pil + 2)) begin
                froze = 1'b1;
                repeat (3) @(negedge clock);
                #1;
                play = 1'b0;
                earHold = ear;
                cnt = 0; changes = 0;
                while (cnt < 100) begin
                    @(negedge clock);
                    if (lastCe) cnt++;
                    if (ear !== earHold || busy !== 1'b1 || sReady !== 1'b0) changes++;
                end
                #1;
                play = 1'b1;
                vectors++;
                if (changes != 0) begin
                    miscompares++;
                    $display("FAIL %s freeze: %0d cycles changed ear/busy/sReady, required 0", name, changes);
                end
            end
        end
        vectors++;
        if (edges - e0 < nP + 1) begin
            miscompares++;
            $display("FAIL %s timeout: saw %0d ear edges, required %0d", name, edges - e0, nP + 1);
            gapAfter = -1;
            return;
        end
        vectors++;
        if (ear !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s end: ear=%b busy=%b, required ear=0 busy=1", name, ear, busy);
        end
`ifdef TAP_PLAYER_PAUSE_EN
        cyc = 0;
        while (busy === 1'b1 && cyc < T_PAUSE * 4 + 100) begin
            @(negedge clock);
            cyc++;
        end
        vectors++;
        if (busy !== 1'b0 || tickAcc != T_PAUSE) begin
            miscompares++;
            $display("FAIL %s pause: busy=%b after %0d ticks, required busy=0 after %0d", name, busy, tickAcc, T_PAUSE);
        end
`else
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pause: busy=%b one cycle after final edge, required 0", name, busy);
        end
`endif
        vectors++;
        if (intervals.size() != nP + 1) begin
            miscompares++;
            $display("FAIL %s edge count: %0d intervals, required %0d", name, intervals.size(), nP + 1);
        end
        for (int k = 0; k < nP && k + 1 < intervals.size(); k++) begin
            if (k == skip) continue;
            vectors++;
            if (intervals[k + 1] != expQ[k]) begin
                miscompares++;
                $display("FAIL %s pulse %0d: measured %0d ticks, required %0d", name, k, intervals[k + 1], expQ[k]);
            end
        end
        if (gapAt > 0) begin
            vectors++;
            if (gapEdges != 0) begin
                miscompares++;
                $display("FAIL %s gap: %0d ear edges during underrun, required 0", name, gapEdges);
            end
            vectors++;
            if (skip + 1 >= intervals.size() || intervals[skip + 1] < expQ[skip] + 1000) begin
                miscompares++;
                $display("FAIL %s stall: stalled pulse too short or missing (%0d intervals), required >= %0d ticks",
                         name, intervals.size(), expQ[skip] + 1000);
            end
        end
        gapAfter = -1;
        $display("block %s: %0d bytes, %0d pulses checked", name, blk.size(), nP);
    endtask

    task automatic test_reset();
        int e0;
        feedQ.push_back(8'h5A);
        lastQ.push_back(1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        vectors += 3;
        if (ear !== 1'b0) begin miscompares++; $display("FAIL reset ear: %b, required 0", ear); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: %b, required 0", busy); end
        if (sReady !== 1'b0) begin miscompares++; $display("FAIL reset sReady: %b with sValid=%b, required 0", sReady, sValid); end
        reset = 1'b1;
        play  = 1'b0;
        e0 = edges;
        repeat (20) @(negedge clock);
        #1;
        vectors += 3;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle freeze busy: %b, required 0", busy); end
        if (sReady !== 1'b0) begin miscompares++; $display("FAIL idle freeze sReady: %b, required 0", sReady); end
        if (edges != e0) begin miscompares++; $display("FAIL idle freeze ear: %0d edges, required 0", edges - e0); end
        feedQ.delete(); lastQ.delete(); sValid = 1'b0; hsPending = 1'b0;
        play = 1'b1;
        $display("reset/idle checks done");
    endtask

    task automatic test_reset_mid_pilot();
        int e0, cyc;
        @(negedge clock); #1;
        feedQ.push_back(8'hFF);
        lastQ.push_back(1'b0);
        e0 = edges; cyc = 0;
        while (edges - e0 < 4 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        vectors++;
        if (edges - e0 < 4) begin
            miscompares++;
            $display("FAIL midpilot start: %0d edges, required >= 4", edges - e0);
        end
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (ear !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midpilot reset: ear=%b busy=%b, required ear=0 busy=0", ear, busy);
        end
        feedQ.delete(); lastQ.delete(); sValid = 1'b0; hsPending = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        $display("reset asserted mid-pilot");
        blk.delete();
        blk.push_back(8'h00);
        runBlock("after_reset", -1, 1'b0);
    endtask

    task automatic test_header_block();
        blk.delete();
        blk.push_back(8'h00);
        runBlock("header_00", -1, 1'b0);
    endtask

    task automatic test_data_block();
        blk.delete();
        blk.push_back(8'hFF);
        blk.push_back(8'h80);
        runBlock("data_ff_80", -1, 1'b0);
    endtask

    task automatic test_underrun();
        blk.delete();
        repeat (3) blk.push_back(8'($urandom));
        runBlock("underrun", 1, 1'b0);
    endtask

    task automatic test_freeze();
        blk.delete();
        repeat (2) blk.push_back(8'($urandom));
        runBlock("freeze_sync2", -1, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            blk.delete();
            repeat ($urandom_range(1, 3)) blk.push_back(8'($urandom));
            runBlock($sformatf("random_%0d", r), -1, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        play  = 1'b1;
        #3;
        test_reset();
        test_reset_mid_pilot();
        test_header_block();
        test_data_block();
        test_underrun();
        test_freeze();
        test_random();
        vectors++;
        if (readyViol != 0) begin
            miscompares++;
            $display("FAIL handshake: sReady high without sValid %0d times, required 0", readyViol);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
